boot_copier: RTL and testbench
==============================

// Module: boot_copier
// PURPOSE
//  Read-side master for the boot ROM: after reset, streams COPY_BYTES from the ROM
//  (1-cycle registered read, XLEN-wide, byte-addressed) into main RAM via a valid/ready
//  write port, holding the core in reset until the copy completes. Sits between the
//  boot ROM and the RAM/interconnect; drives the core's reset release.
// PARAMETERS
//  XLEN            64            data width; BYTES = XLEN/8 per beat
//  BROM_SIZE_BYTES 4096          ROM size; ADDRWIDTH = $clog2(BROM_SIZE_BYTES)
//  COPY_BYTES      4096          bytes to copy; 0..BROM_SIZE_BYTES (elaboration error otherwise)
//  RAM_BASE        64'h8000_0000 destination of byte 0; must be BYTES-aligned
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          reset, asynchronous assert, active-low
//  rom_addr       out  ADDRWIDTH  ROM byte address, always BYTES-aligned
//  rom_rdata      in   XLEN       ROM data, valid the cycle after rom_addr is presented
//  ram_valid      out  1          write request valid
//  ram_ready      in   1          RAM accepts request when ram_valid && ram_ready
//  ram_addr       out  XLEN       write byte address
//  ram_wdata      out  XLEN       write data, little-endian: byte k in [8k+7:8k]
//  ram_wstrb      out  XLEN/8     byte enables
//  busy           out  1          copy in progress
//  done           out  1          copy finished; sticky until reset
//  cpu_rst_n      out  1          core reset; low until done
// BEHAVIOUR
//  - Reset (async): state=IDLE, beat=0, all outputs 0 (rom_addr=0, ram_*=0, busy=0,
//    done=0, cpu_rst_n=0). Reset mid-copy aborts immediately; ram_valid drops the same
//    instant. On release, the copy restarts from beat 0.
//  - NBEATS = ceil(COPY_BYTES/BYTES). FSM: IDLE -> READ -> CAPT -> WRITE -> (READ | DONE).
//    IDLE: 1st cycle after reset release; go to DONE if NBEATS==0, else READ.
//    READ: rom_addr = beat*BYTES.  CAPT: register rom_rdata into ram_wdata;
//    ram_addr = RAM_BASE + beat*BYTES; set wstrb. WRITE: ram_valid=1 until accepted.
//    On accept: if beat==NBEATS-1 go to DONE, else beat++ and go to READ.
//  - Throughput: 3 cycles/beat with ram_ready=1. No ROM pipelining.
//  - Handshake: once ram_valid is high, ram_valid/addr/wdata/wstrb stay stable until
//    accepted; ram_valid never drops without acceptance (except on reset). Exactly one
//    accept per beat; no duplication or skipping.
//  - wstrb: all ones, except the last beat when COPY_BYTES%BYTES != 0:
//    low (COPY_BYTES%BYTES) bits set. Data bytes beyond the tail are don't-care.
//  - busy=1 in READ/CAPT/WRITE. DONE: done=1 and cpu_rst_n=1 (registered, from the
//    cycle after the final accept), ram_valid=0. DONE holds until reset.
//  - Width: beat counter is $clog2(NBEATS+1) bits. Address arithmetic is in XLEN
//    (RAM) and ADDRWIDTH (ROM). rom_addr never exceeds BROM_SIZE_BYTES-BYTES; no wrap.
// STRUCTURE
//  - Shared package boot_pkg: state enum (IDLE, READ, CAPT, WRITE, DONE), default
//    RAM_BASE, and the tail-strobe function wstrb_for(count) -> logic [XLEN/8-1:0].
//  - Single module with no sub-module. The bench instantiates the existing boot ROM as
//    the responder, plus a RAM model with programmable ready stalls.
// TESTING
//  1 ROM byte i = i[7:0], COPY_BYTES=32, ready=1 -> 4 accepts at 0x8000_0000/+8/+10/+18;
//    first wdata 64'h0706050403020100, wstrb 8'hFF; done=cpu_rst_n=1 after last accept.
//  2 Backpressure: ready=0 for 5 cycles on beat 2 -> valid/addr/wdata/wstrb held stable;
//    4 accepts total, in order, no duplicates.
//  3 COPY_BYTES=20 -> 3 beats; last beat addr 0x8000_0010, wstrb 8'h0F.
//  4 rst_n low while beat 2 is in WRITE -> ram_valid=0, busy=0, done=0, cpu_rst_n=0
//    asynchronously; after release, first accept is again at 0x8000_0000.
//  5 COPY_BYTES=0 -> no ram_valid; done=1 in the 2nd cycle after reset release.
//  6 COPY_BYTES=4096 -> 512 accepts; max rom_addr 0xFF8, last ram_addr 0x8000_0FF8;
//    RAM contents match the ROM byte-for-byte.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot ROM copier: FSM state encoding, default RAM base
// address and the byte-enable helper used for the final, possibly partial, beat.
package boot_pkg;

  // Widest strobe the helper can produce (XLEN up to 512).
  localparam int unsigned STRB_MAX = 64;

  localparam logic [63:0] RAM_BASE_DEFAULT = 64'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    WRITE,
    DONE
  } boot_state_e;

  // Byte enables with the low 'count' lanes set; callers slice to their own width.
  function automatic logic [STRB_MAX-1:0] wstrb_for(input int unsigned count);
    logic [STRB_MAX-1:0] s;
    s = '0;
    for (int unsigned k = 0; k < STRB_MAX; k++) begin
      if (k < count) s[k] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/boot_copier.sv
// Boot copier: after reset, copies COPY_BYTES from the boot ROM into RAM one beat at
// a time over a valid/ready write port, holding the core in reset until finished.
module boot_copier
  import boot_pkg::*;
#(
  parameter int unsigned      XLEN            = 64,
  parameter int unsigned      BROM_SIZE_BYTES = 4096,
  parameter int unsigned      COPY_BYTES      = 4096,
  parameter logic [XLEN-1:0]  RAM_BASE        = XLEN'(RAM_BASE_DEFAULT),
  localparam int unsigned     ADDRWIDTH       = $clog2(BROM_SIZE_BYTES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [XLEN-1:0]      rom_rdata,
  output logic                 ram_valid,
  input  logic                 ram_ready,
  output logic [XLEN-1:0]      ram_addr,
  output logic [XLEN-1:0]      ram_wdata,
  output logic [XLEN/8-1:0]    ram_wstrb,
  output logic                 busy,
  output logic                 done,
  output logic                 cpu_rst_n
);

  localparam int unsigned BYTES  = XLEN / 8;
  localparam int unsigned BSHIFT = $clog2(BYTES);
  localparam int unsigned NBEATS = (COPY_BYTES + BYTES - 1) / BYTES;
  localparam int unsigned BEATW  = (NBEATS < 2) ? 1 : $clog2(NBEATS + 1);
  localparam int unsigned TAIL   = COPY_BYTES % BYTES;

  localparam logic [STRB_MAX-1:0] LAST_STRB_FULL = wstrb_for((TAIL == 0) ? BYTES : TAIL);
  localparam logic [BYTES-1:0]    LAST_STRB      = LAST_STRB_FULL[BYTES-1:0];
  localparam logic [BEATW-1:0]    LAST_BEAT      = (NBEATS == 0) ? '0 : BEATW'(NBEATS - 1);

  if (COPY_BYTES > BROM_SIZE_BYTES) begin : g_chk_copy
    $error("boot_copier: COPY_BYTES exceeds BROM_SIZE_BYTES");
  end
  if ((RAM_BASE % XLEN'(BYTES)) != '0) begin : g_chk_base
    $error("boot_copier: RAM_BASE is not beat-aligned");
  end
  if (BYTES > STRB_MAX) begin : g_chk_xlen
    $error("boot_copier: XLEN too wide for wstrb_for");
  end

  boot_state_e      state;
  boot_state_e      state_nxt;
  logic [BEATW-1:0] beat;
  logic             last_beat;

  always_comb last_beat = (beat == LAST_BEAT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one ROM read, one capture, then hold the write until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (NBEATS == 0) ? DONE : READ;
      READ:    state_nxt = CAPT;
      CAPT:    state_nxt = WRITE;
      WRITE:   if (ram_ready) state_nxt = last_beat ? DONE : READ;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter and write-request registers; the request is frozen outside CAPT,
  // which keeps addr/data/strobe stable for as long as WRITE waits on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wstrb <= '0;
    end else begin
      if (state == CAPT) begin
        ram_wdata <= rom_rdata;
        ram_addr  <= RAM_BASE + (XLEN'(beat) << BSHIFT);
        ram_wstrb <= last_beat ? LAST_STRB : '1;
      end
      if ((state == WRITE) && ram_ready && !last_beat) begin
        beat <= beat + BEATW'(1);
      end
    end
  end

  // Outputs decoded from the state register, so reset clears them immediately.
  always_comb begin
    rom_addr  = ADDRWIDTH'(beat) << BSHIFT;
    ram_valid = (state == WRITE);
    busy      = (state == READ) || (state == CAPT) || (state == WRITE);
    done      = (state == DONE);
    cpu_rst_n = (state == DONE);
  end

endmodule

// File: tb/tb_boot_copier.sv
// Bench for boot_copier: four copies with different COPY_BYTES run side by side
// against a ROM responder, a ready-stalling RAM port and a beat-level reference model.
`timescale 1ns/1ps
module tb_boot_copier;
  import boot_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned CB [N] = '{32, 20, 0, 4096};
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [N];
  logic [11:0] rom_addr  [N];
  logic [63:0] rom_rdata [N];
  logic        ram_valid [N];
  logic        ram_ready [N];
  logic [63:0] ram_addr  [N];
  logic [63:0] ram_wdata [N];
  logic [7:0]  ram_wstrb [N];
  logic        busy      [N];
  logic        done      [N];
  logic        cpu_rst_n [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    boot_copier #(
      .XLEN(64),
      .BROM_SIZE_BYTES(4096),
      .COPY_BYTES(CB[g]),
      .RAM_BASE(BASE)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n[g]),
      .rom_addr(rom_addr[g]),
      .rom_rdata(rom_rdata[g]),
      .ram_valid(ram_valid[g]),
      .ram_ready(ram_ready[g]),
      .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_wstrb(ram_wstrb[g]),
      .busy(busy[g]),
      .done(done[g]),
      .cpu_rst_n(cpu_rst_n[g])
    );
  end

  // ROM contents: byte i = i[7:0] over the first 256 bytes, upper address bits mixed in.
  function automatic logic [7:0] rom_byte(input int unsigned a);
    logic [11:0] av;
    av = a[11:0];
    return av[7:0] ^ (8'(av[11:8]) * 8'h3B);
  endfunction

  function automatic logic [63:0] rom_word(input int unsigned a);
    logic [63:0] w;
    for (int unsigned k = 0; k < 8; k++) w[8*k +: 8] = rom_byte(a + k);
    return w;
  endfunction

  function automatic logic [7:0] exp_strb(input int unsigned i, input int unsigned b);
    int unsigned n;
    logic [15:0] t;
    n = CB[i] - 8 * b;
    if (n > 8) n = 8;
    t = (16'd1 << n) - 16'd1;
    return t[7:0];
  endfunction

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int unsigned k = 0; k < 8; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction

  // ROM responder: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) rom_rdata[i] <= rom_word(int'(rom_addr[i]));
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic void chk(input string name, input int idx,
                              input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endfunction

  // Reference model state, advanced at each rising edge.
  int unsigned acc   [N];
  int unsigned edges [N];
  logic        pend  [N];
  logic        got_first  [N];
  logic [63:0] first_addr [N];
  logic [63:0] first_data [N];
  logic [7:0]  first_strb [N];
  logic [63:0] last_addr  [N];
  logic [7:0]  last_strb  [N];
  logic [63:0] q0[$];
  logic [7:0]  ram_img [4096];

  initial begin
    for (int i = 0; i < N; i++) begin
      acc[i] = 0; edges[i] = 0; pend[i] = 1'b0; got_first[i] = 1'b0;
      first_addr[i] = '0; first_data[i] = '0; first_strb[i] = '0;
      last_addr[i] = '0; last_strb[i] = '0;
    end
    for (int a = 0; a < 4096; a++) ram_img[a] = ~rom_byte(a);
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n[i]) begin
          acc[i] = 0; edges[i] = 0; pend[i] = 1'b0; got_first[i] = 1'b0;
          if (i == 0) q0.delete();
        end else begin
          edges[i]++;
          pend[i] = ram_valid[i] && !ram_ready[i];
          if (ram_valid[i] && ram_ready[i]) begin
            if (!got_first[i]) begin
              got_first[i]  = 1'b1;
              first_addr[i] = ram_addr[i];
              first_data[i] = ram_wdata[i];
              first_strb[i] = ram_wstrb[i];
            end
            last_addr[i] = ram_addr[i];
            last_strb[i] = ram_wstrb[i];
            if (i == 0) q0.push_back(ram_addr[i]);
            if (i == 3) begin
              for (int k = 0; k < 8; k++) begin
                int unsigned off;
                off = int'(ram_addr[i] - BASE) + k;
                if (ram_wstrb[i][k] && off < 4096) ram_img[off] = ram_wdata[i][8*k +: 8];
              end
            end
            acc[i]++;
          end
        end
      end
    end
  end

  // Compare process: every falling edge, every instance.
  int unsigned max_rom    [N];
  int unsigned first_done [N];

  task automatic cmp_one(input int i);
    int unsigned nb;
    logic        de;
    logic [7:0]  s;
    nb = (CB[i] + 7) / 8;
    if (!rst_n[i]) begin
      chk("rst_ctrl", i, 64'({ram_valid[i], busy[i], done[i], cpu_rst_n[i]}), 64'd0);
      chk("rst_rom_addr", i, 64'(rom_addr[i]), 64'd0);
      chk("rst_ram_addr", i, ram_addr[i], 64'd0);
      chk("rst_ram_wdata", i, ram_wdata[i], 64'd0);
      chk("rst_ram_wstrb", i, 64'(ram_wstrb[i]), 64'd0);
      first_done[i] = 32'hFFFF_FFFF;
      max_rom[i]    = 0;
    end else begin
      de = (acc[i] == nb) && (edges[i] >= 1);
      chk("done", i, 64'(done[i]), 64'(de));
      chk("cpu_rst_n", i, 64'(cpu_rst_n[i]), 64'(de));
      chk("busy", i, 64'(busy[i]), 64'((edges[i] >= 1) && !de));
      if (done[i] && first_done[i] == 32'hFFFF_FFFF) first_done[i] = edges[i];
      chk("rom_addr_ok", i, 64'((rom_addr[i][2:0] == 3'd0) && (rom_addr[i] <= 12'hFF8)), 64'd1);
      if (int'(rom_addr[i]) > max_rom[i]) max_rom[i] = int'(rom_addr[i]);
      if (pend[i]) chk("valid_held", i, 64'(ram_valid[i]), 64'd1);
      if (ram_valid[i]) begin
        chk("valid_in_range", i, 64'(acc[i] < nb), 64'd1);
        if (acc[i] < nb) begin
          s = exp_strb(i, acc[i]);
          chk("ram_addr", i, ram_addr[i], BASE + 64'(8 * acc[i]));
          chk("ram_wstrb", i, 64'(ram_wstrb[i]), 64'(s));
          chk("ram_wdata", i, ram_wdata[i] & strb_mask(s),
              rom_word(8 * acc[i]) & strb_mask(s));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      max_rom[i] = 0;
      first_done[i] = 32'hFFFF_FFFF;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) cmp_one(i);
    end
  end

  // RAM-side ready generation: instance 0 is either always ready or stalls five
  // cycles on beat 2; the others see random backpressure.
  logic        stall_mode = 1'b0;
  int unsigned stall_used;

  initial begin
    for (int i = 0; i < N; i++) ram_ready[i] = 1'b1;
    stall_used = 0;
    forever begin
      @(negedge clk);
      ram_ready[0] = 1'b1;
      if (!rst_n[0]) stall_used = 0;
      else if (stall_mode && stall_used < 5 && ram_valid[0] && acc[0] == 2) begin
        ram_ready[0] = 1'b0;
        stall_used++;
      end
      ram_ready[1] = ($urandom_range(0, 3) != 0);
      ram_ready[2] = 1'($urandom_range(0, 1));
      ram_ready[3] = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_done(input int i, input int maxc);
    int n;
    n = 0;
    while (!done[i] && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", i, 64'(done[i]), 64'd1);
  endtask

  task automatic pulse_rst0();
    @(negedge clk); #2; rst_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2; rst_n[0] = 1'b1;
  endtask

  task automatic check_q0();
    chk("accept_count", 0, 64'(q0.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < q0.size()) chk("accept_addr", k, q0[k], BASE + 64'(8 * k));
    end
  endtask

  initial begin
    int n;
    int unsigned mism;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    // 32-byte copy, always ready.
    wait_done(0, 200);
    check_q0();
    chk("first_addr", 0, first_addr[0], 64'h0000_0000_8000_0000);
    chk("first_wdata", 0, first_data[0], 64'h0706050403020100);
    chk("first_wstrb", 0, 64'(first_strb[0]), 64'hFF);
    chk("done_cycle", 0, 64'(first_done[0]), 64'd13);

    // 20-byte copy: partial last beat.
    wait_done(1, 5000);
    chk("beats", 1, 64'(acc[1]), 64'd3);
    chk("last_addr", 1, last_addr[1], 64'h0000_0000_8000_0010);
    chk("last_wstrb", 1, 64'(last_strb[1]), 64'h0F);

    // Empty copy.
    chk("done_cycle", 2, 64'(first_done[2]), 64'd1);
    chk("beats", 2, 64'(acc[2]), 64'd0);

    // Backpressure on beat 2.
    stall_mode = 1'b1;
    pulse_rst0();
    wait_done(0, 200);
    stall_mode = 1'b0;
    check_q0();
    chk("stall_cycles", 0, 64'(stall_used), 64'd5);
    chk("done_cycle_stall", 0, 64'(first_done[0]), 64'd18);

    // Asynchronous reset while beat 2 is waiting in WRITE.
    pulse_rst0();
    n = 0;
    while (!(ram_valid[0] && acc[0] == 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_beat2", 0, 64'(ram_valid[0] && acc[0] == 2), 64'd1);
    #2; rst_n[0] = 1'b0;
    #1;
    chk("async_valid", 0, 64'(ram_valid[0]), 64'd0);
    chk("async_busy", 0, 64'(busy[0]), 64'd0);
    chk("async_done", 0, 64'(done[0]), 64'd0);
    chk("async_cpu_rst_n", 0, 64'(cpu_rst_n[0]), 64'd0);
    repeat (2) @(negedge clk);
    #2; rst_n[0] = 1'b1;
    wait_done(0, 200);
    chk("restart_first_addr", 0, first_addr[0], 64'h0000_0000_8000_0000);
    check_q0();

    // Full 4 KiB copy under random backpressure.
    wait_done(3, 20000);
    chk("beats", 3, 64'(acc[3]), 64'd512);
    chk("max_rom_addr", 3, 64'(max_rom[3]), 64'hFF8);
    chk("last_addr", 3, last_addr[3], 64'h0000_0000_8000_0FF8);
    mism = 0;
    for (int a = 0; a < 4096; a++) if (ram_img[a] !== rom_byte(a)) mism++;
    chk("ram_image", 3, 64'(mism), 64'd0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
